// File: rtl/rc4_key_dispatcher.sv
// rtl/rc4_key_dispatcher.sv - on-demand chunk dispatcher and found-key collector for RC4 key search cores
module rc4_key_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int KEY_WIDTH  = 24,
    parameter int CHUNK_LOG2 = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [KEY_WIDTH-1:0]           key_start,
    input  logic [KEY_WIDTH-1:0]           key_end,
    input  logic [NUM_CORES-1:0]           req,
    input  logic [NUM_CORES-1:0]           found,
    input  logic [NUM_CORES*KEY_WIDTH-1:0] found_key_bus,
    output logic [NUM_CORES-1:0]           grant,
    output logic [KEY_WIDTH-1:0]           grant_key,
    output logic [CHUNK_LOG2:0]            grant_count,
    output logic                           stop_all,
    output logic                           busy,
    output logic                           key_found,
    output logic                           key_exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [$clog2(NUM_CORES):0]     found_core,
    output logic [KEY_WIDTH:0]             keys_dispatched,
    output logic [31:0]                    search_cycles
);
    localparam int IW = $clog2(NUM_CORES) + 1;
    localparam logic [KEY_WIDTH:0] CHUNK_KEYS = (KEY_WIDTH+1)'(1) << CHUNK_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_EXHAUSTED} state_t;

    state_t               state, state_next;
    logic                 start_q;
    logic [KEY_WIDTH-1:0] key_end_r;
    // One bit of headroom so a range ending at the top key terminates instead of wrapping.
    logic [KEY_WIDTH:0]   next_key;
    logic [IW-1:0]        last_core;

    logic                 start_rise;
    logic [NUM_CORES-1:0] req_eff;
    logic                 keys_left;
    logic [KEY_WIDTH:0]   remaining;
    logic [KEY_WIDTH:0]   chunk_cnt;
    logic                 hi_valid, lo_valid, pick_valid;
    logic [IW-1:0]        hi_idx, lo_idx, pick;
    logic                 do_grant;
    logic [NUM_CORES-1:0] grant_vec;
    logic                 found_any;
    logic [IW-1:0]        found_idx;
    logic [KEY_WIDTH-1:0] found_sel;
    logic                 exhaust;

    assign start_rise    = start & ~start_q;
    assign busy          = (state == S_RUN);
    assign key_found     = (state == S_FOUND);
    assign stop_all      = (state == S_FOUND);
    assign key_exhausted = (state == S_EXHAUSTED);

    // Chunk sizing, round-robin pick and lowest-index found selection.
    always_comb begin
        // A core still shows req in the cycle it sees its grant; that req is stale.
        req_eff   = req & ~grant;
        keys_left = (next_key <= {1'b0, key_end_r});
        remaining = {1'b0, key_end_r} - next_key + (KEY_WIDTH+1)'(1);
        chunk_cnt = (remaining < CHUNK_KEYS) ? remaining : CHUNK_KEYS;

        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (req_eff[i] && (i > int'(last_core)) && !hi_valid) begin
                hi_valid = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req_eff[i] && !lo_valid) begin
                lo_valid = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        pick_valid = hi_valid | lo_valid;
        pick       = hi_valid ? hi_idx : lo_idx;

        found_any = 1'b0;
        found_idx = '0;
        found_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (found[i] && !found_any) begin
                found_any = 1'b1;
                found_idx = IW'(i);
                found_sel = found_key_bus[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end

        do_grant = (state == S_RUN) && !found_any && keys_left && pick_valid;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_vec[i] = do_grant && (IW'(i) == pick);
        end

        exhaust = !keys_left && (&req) && (grant == '0) && !found_any;
    end

    // Next-state logic; FOUND and EXHAUSTED only leave through reset.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_next = (key_start > key_end) ? S_EXHAUSTED : S_RUN;
                end
            end
            S_RUN: begin
                if (found_any) begin
                    state_next = S_FOUND;
                end else if (exhaust) begin
                    state_next = S_EXHAUSTED;
                end
            end
            default: state_next = state;
        endcase
    end

    // State, range, grant and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            start_q         <= 1'b0;
            key_end_r       <= '0;
            next_key        <= '0;
            last_core       <= IW'(NUM_CORES - 1);
            grant           <= '0;
            grant_key       <= '0;
            grant_count     <= '0;
            found_key       <= '0;
            found_core      <= '0;
            keys_dispatched <= '0;
            search_cycles   <= '0;
        end else begin
            state   <= state_next;
            start_q <= start;
            grant   <= grant_vec;
            if (state == S_IDLE && start_rise) begin
                key_end_r <= key_end;
                next_key  <= {1'b0, key_start};
            end
            if (do_grant) begin
                grant_key       <= next_key[KEY_WIDTH-1:0];
                grant_count     <= chunk_cnt[CHUNK_LOG2:0];
                next_key        <= next_key + chunk_cnt;
                keys_dispatched <= keys_dispatched + chunk_cnt;
                last_core       <= pick;
            end
            if (state == S_RUN && found_any) begin
                found_key  <= found_sel;
                found_core <= found_idx;
            end
            if (state == S_RUN && search_cycles != '1) begin
                search_cycles <= search_cycles + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// tb/tb_rc4_key_dispatcher.sv - directed self-checking bench for rc4_key_dispatcher
module tb_rc4_key_dispatcher;
    localparam int NC  = 4;
    localparam int KW  = 24;
    localparam int CL  = 8;
    localparam int KW2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start;
    logic [NC-1:0]     req, found;
    logic [KW-1:0]     key_start, key_end;
    logic [NC*KW-1:0]  found_key_bus;
    logic [NC-1:0]     grant;
    logic [KW-1:0]     grant_key;
    logic [CL:0]       grant_count;
    logic              stop_all, busy, key_found, key_exhausted;
    logic [KW-1:0]     found_key;
    logic [2:0]        found_core;
    logic [KW:0]       keys_dispatched;
    logic [31:0]       search_cycles;

    logic [KW2-1:0]    key_start2, key_end2;
    logic [NC*KW2-1:0] found_key_bus2;
    logic [NC-1:0]     grant2;
    logic [KW2-1:0]    grant_key2;
    logic [CL:0]       grant_count2;
    logic              stop_all2, busy2, key_found2, key_exhausted2;
    logic [KW2-1:0]    found_key2;
    logic [2:0]        found_core2;
    logic [KW2:0]      keys_dispatched2;
    logic [31:0]       search_cycles2;

    rc4_key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .CHUNK_LOG2(CL)) dut (
        .clk(clk), .reset(reset), .start(start), .key_start(key_start), .key_end(key_end),
        .req(req), .found(found), .found_key_bus(found_key_bus), .grant(grant),
        .grant_key(grant_key), .grant_count(grant_count), .stop_all(stop_all), .busy(busy),
        .key_found(key_found), .key_exhausted(key_exhausted), .found_key(found_key),
        .found_core(found_core), .keys_dispatched(keys_dispatched), .search_cycles(search_cycles)
    );

    rc4_key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW2), .CHUNK_LOG2(CL)) dut2 (
        .clk(clk), .reset(reset), .start(start), .key_start(key_start2), .key_end(key_end2),
        .req(req), .found(found), .found_key_bus(found_key_bus2), .grant(grant2),
        .grant_key(grant_key2), .grant_count(grant_count2), .stop_all(stop_all2), .busy(busy2),
        .key_found(key_found2), .key_exhausted(key_exhausted2), .found_key(found_key2),
        .found_core(found_core2), .keys_dispatched(keys_dispatched2), .search_cycles(search_cycles2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        req   = '0;
        found = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [KW-1:0] ks;
        logic [KW-1:0] ke;
        int            n_grants;
        logic [KW-1:0] first_key;
        logic [CL:0]   first_count;
        logic [KW-1:0] last_key;
        logic [CL:0]   last_count;
        logic [NC-1:0] last_grant;
        logic [KW:0]   dispatched;
        int            cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int            n;
        logic [KW-1:0] fk, lk;
        logic [CL:0]   fc, lc;
        logic [NC-1:0] lg;
        logic [NC-1:0] exp_seq[4];
        logic [KW2+1:0] sum2;
        bit            done;

        vecs[0] = '{24'h000000, 24'h0003FF, 4, 24'h000000, 9'd256, 24'h000300, 9'd256, 4'b1000, 25'h400, 6};
        vecs[1] = '{24'h000010, 24'h00011F, 2, 24'h000010, 9'd256, 24'h000110, 9'd16,  4'b0010, 25'h110, 4};
        vecs[2] = '{24'h000005, 24'h000004, 0, 24'h000000, 9'd0,   24'h000000, 9'd0,   4'b0000, 25'h0,   0};
        vecs[3] = '{24'h000000, 24'h000000, 1, 24'h000000, 9'd1,   24'h000000, 9'd1,   4'b0001, 25'h1,   3};
        vecs[4] = '{24'hFFFF00, 24'hFFFFFF, 1, 24'hFFFF00, 9'd256, 24'hFFFF00, 9'd256, 4'b0001, 25'h100, 3};

        key_start = '0; key_end = '0; found_key_bus = '0;
        key_start2 = '0; key_end2 = '0; found_key_bus2 = '0;
        do_reset();

        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_stop_all", stop_all, 0);
        check("rst_exhausted", key_exhausted, 0);
        check("rst_dispatched", keys_dispatched, 0);
        check("rst_cycles", search_cycles, 0);
        check("rst_found_core", found_core, 0);

        // Range table: all req held, no found.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            key_start = vecs[v].ks;
            key_end   = vecs[v].ke;
            req       = '1;
            start     = 1'b1;
            n = 0; fk = '0; fc = '0; lk = '0; lc = '0; lg = '0; done = 0;
            for (int c = 0; c < 200 && !done; c++) begin
                tick();
                if (grant != '0) begin
                    if (n == 0) begin
                        fk = grant_key;
                        fc = grant_count;
                    end
                    lk = grant_key; lc = grant_count; lg = grant;
                    n++;
                end
                if (key_exhausted || key_found) done = 1;
            end
            check($sformatf("v%0d_exhausted", v), key_exhausted, 1);
            check($sformatf("v%0d_n_grants", v), n, vecs[v].n_grants);
            check($sformatf("v%0d_first_key", v), fk, vecs[v].first_key);
            check($sformatf("v%0d_first_count", v), fc, vecs[v].first_count);
            check($sformatf("v%0d_last_key", v), lk, vecs[v].last_key);
            check($sformatf("v%0d_last_count", v), lc, vecs[v].last_count);
            check($sformatf("v%0d_last_grant", v), lg, vecs[v].last_grant);
            check($sformatf("v%0d_dispatched", v), keys_dispatched, vecs[v].dispatched);
            check($sformatf("v%0d_cycles", v), search_cycles, vecs[v].cycles);
            check($sformatf("v%0d_busy", v), busy, 0);
        end

        // Simultaneous found on cores 1 and 3.
        do_reset();
        key_start = 24'h0; key_end = 24'hFFFFFF; req = '1; start = 1'b1;
        tick(); tick(); tick();
        found = 4'b1010;
        found_key_bus = {24'h0ABCDF, 24'h111111, 24'h0ABCDE, 24'h222222};
        tick();
        found = '0;
        check("found_key_found", key_found, 1);
        check("found_stop_all", stop_all, 1);
        check("found_key", found_key, 24'h0ABCDE);
        check("found_core", found_core, 1);
        check("found_grant_suppressed", grant, 0);
        check("found_busy", busy, 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                found = 4'b0001;
                found_key_bus = {24'h0, 24'h0, 24'h0, 24'h123456};
            end else begin
                found = '0;
            end
            tick();
            if (grant != '0) n++;
        end
        found = '0;
        check("found_no_more_grants", n, 0);
        check("found_key_held", found_key, 24'h0ABCDE);
        check("found_core_held", found_core, 1);
        check("found_not_exhausted", key_exhausted, 0);

        // Reset while a grant decision is pending, then restart.
        do_reset();
        key_start = 24'h20; key_end = 24'hFFFFFF; req = '1; start = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1; start = 1'b0;
        tick();
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dispatched", keys_dispatched, 0);
        check("midrst_grant_key", grant_key, 0);
        check("midrst_grant_count", grant_count, 0);
        check("midrst_cycles", search_cycles, 0);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick(); tick();
        check("restart_grant", grant, 4'b0001);
        check("restart_key", grant_key, 24'h20);
        check("restart_count", grant_count, 256);

        // Fairness: core 2 alone, then cores 0 and 2 together.
        do_reset();
        key_start = 24'h0; key_end = 24'hFFFFFF; req = 4'b0100; start = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            tick();
            if (grant != '0) begin
                check($sformatf("fair_solo_grant%0d", n), grant, 4'b0100);
                check($sformatf("fair_solo_key%0d", n), grant_key, 24'(n * 256));
                n++;
            end
        end
        check("fair_solo_n", n, 3);
        req = 4'b0101;
        exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("fair_alt_grant%0d", k), grant, exp_seq[k]);
            check($sformatf("fair_alt_key%0d", k), grant_key, 24'((k + 3) * 256));
        end

        // Full 12-bit key space on the second instance.
        do_reset();
        key_start2 = '0; key_end2 = 12'hFFF; req = '1; start = 1'b1;
        n = 0; sum2 = '0; lk = '0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (grant2 != '0) begin
                n++;
                sum2 = sum2 + 14'(grant_count2);
                lk = 24'(grant_key2);
            end
            if (key_exhausted2) done = 1;
        end
        check("full_exhausted", key_exhausted2, 1);
        check("full_n_grants", n, 16);
        check("full_sum", sum2, 14'h1000);
        check("full_last_key", lk, 24'hF00);
        check("full_dispatched", keys_dispatched2, 13'h1000);
        check("full_busy", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
